// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - RV32I pipeline stall/flush sequencer with memory watchdog
// Optional HAZARD_PERF_CNT_EN adds Stall_Count / Flush_Count performance counters.
module hazard_controller #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_RS1,
  input  logic [4:0]       IF_ID_RS2,
  input  logic             IF_ID_UsesRS1,
  input  logic             IF_ID_UsesRS2,
  input  logic [4:0]       ID_EX_RD,
  input  logic             ID_EX_MemRead,
  input  logic             EX_BranchTaken,
  input  logic             MEM_Req,
  input  logic             MEM_Ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             ID_EX_Write,
  output logic             EX_MEM_Write,
  output logic             MEM_WB_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic [1:0]       State,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count,
`endif
  output logic             Mem_Timeout
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_HALT     = 2'b11
  } state_e;

  localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;

  logic load_use;
  logic mem_stall;

  assign load_use = ID_EX_MemRead && (ID_EX_RD != 5'd0) &&
                    ((IF_ID_UsesRS1 && (IF_ID_RS1 == ID_EX_RD)) ||
                     (IF_ID_UsesRS2 && (IF_ID_RS2 == ID_EX_RD)));
  assign mem_stall = MEM_Req && !MEM_Ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      cnt_q     <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d = ST_MEM_WAIT;
          cnt_d   = 16'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_stall) begin
          if (cnt_q >= TIMEOUT) begin
            state_d   = ST_HALT;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else begin
          state_d = ST_RUN;
          cnt_d   = 16'd0;
        end
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // Leaving MEM_WAIT on a non-stalled cycle decodes exactly like RUN.
  always_comb begin
    PC_Write     = 1'b0;
    IF_ID_Write  = 1'b0;
    ID_EX_Write  = 1'b0;
    EX_MEM_Write = 1'b0;
    MEM_WB_Write = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    if (!reset && !mem_stall && (state_q != ST_HALT)) begin
      PC_Write     = 1'b1;
      IF_ID_Write  = 1'b1;
      ID_EX_Write  = 1'b1;
      EX_MEM_Write = 1'b1;
      MEM_WB_Write = 1'b1;
      if (EX_BranchTaken) begin
        IF_ID_Flush = 1'b1;
        ID_EX_Flush = 1'b1;
      end else if (load_use) begin
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
        ID_EX_Flush = 1'b1;
      end
    end
  end

  assign State       = state_q;
  assign Mem_Timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!PC_Write) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (IF_ID_Flush) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign Stall_Count = stall_cnt_q;
  assign Flush_Count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed vector bench for hazard_controller
module tb_hazard_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  IF_ID_RS1, IF_ID_RS2, ID_EX_RD;
  logic        IF_ID_UsesRS1, IF_ID_UsesRS2, ID_EX_MemRead;
  logic        EX_BranchTaken, MEM_Req, MEM_Ready;
  logic        PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write;
  logic        IF_ID_Flush, ID_EX_Flush, Mem_Timeout;
  logic [1:0]  State;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] Stall_Count, Flush_Count;
  logic [31:0] s0, f0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .IF_ID_RS1(IF_ID_RS1), .IF_ID_RS2(IF_ID_RS2),
    .IF_ID_UsesRS1(IF_ID_UsesRS1), .IF_ID_UsesRS2(IF_ID_UsesRS2),
    .ID_EX_RD(ID_EX_RD), .ID_EX_MemRead(ID_EX_MemRead),
    .EX_BranchTaken(EX_BranchTaken), .MEM_Req(MEM_Req), .MEM_Ready(MEM_Ready),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .ID_EX_Write(ID_EX_Write),
    .EX_MEM_Write(EX_MEM_Write), .MEM_WB_Write(MEM_WB_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
    .State(State),
`ifdef HAZARD_PERF_CNT_EN
    .Stall_Count(Stall_Count), .Flush_Count(Flush_Count),
`endif
    .Mem_Timeout(Mem_Timeout)
  );

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       mr, br, req, rdy;
    logic [6:0] exp_ctl;   // {PC,IF_ID,ID_EX,EX_MEM,MEM_WB,IF_ID_Flush,ID_EX_Flush}
    logic [1:0] exp_state;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [6:0] ctl();
    return {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write,
            IF_ID_Flush, ID_EX_Flush};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    IF_ID_RS1 = v.rs1; IF_ID_RS2 = v.rs2;
    IF_ID_UsesRS1 = v.u1; IF_ID_UsesRS2 = v.u2;
    ID_EX_RD = v.rd; ID_EX_MemRead = v.mr;
    EX_BranchTaken = v.br; MEM_Req = v.req; MEM_Ready = v.rdy;
  endtask

  task automatic idle();
    IF_ID_RS1 = 5'd0; IF_ID_RS2 = 5'd0; IF_ID_UsesRS1 = 1'b0; IF_ID_UsesRS2 = 1'b0;
    ID_EX_RD = 5'd0; ID_EX_MemRead = 1'b0; EX_BranchTaken = 1'b0;
    MEM_Req = 1'b0; MEM_Ready = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           rs1   rs2   u1 u2 rd    mr br req rdy  ctl         state
    vecs[0]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 7'b1111100, 2'b00};
    vecs[1]  = '{5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0, 7'b0011101, 2'b00};
    vecs[2]  = '{5'd0, 5'd0, 0, 1, 5'd0, 1, 0, 0, 0, 7'b1111100, 2'b00};
    vecs[3]  = '{5'd0, 5'd5, 0, 0, 5'd5, 1, 0, 0, 0, 7'b1111100, 2'b00};
    vecs[4]  = '{5'd7, 5'd0, 1, 0, 5'd7, 1, 0, 0, 0, 7'b0011101, 2'b00};
    vecs[5]  = '{5'd7, 5'd0, 1, 0, 5'd7, 0, 0, 0, 0, 7'b1111100, 2'b00};
    vecs[6]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 7'b1111111, 2'b00};
    vecs[7]  = '{5'd7, 5'd0, 1, 0, 5'd7, 1, 1, 0, 0, 7'b1111111, 2'b00};
    vecs[8]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 7'b1111100, 2'b00};
    vecs[9]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, 7'b0000000, 2'b00};
    vecs[10] = '{5'd7, 5'd0, 1, 0, 5'd7, 1, 0, 1, 1, 7'b0011101, 2'b01};
    vecs[11] = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 7'b1111100, 2'b00};
    vecs[12] = '{5'd9, 5'd3, 0, 1, 5'd3, 1, 0, 0, 0, 7'b0011101, 2'b00};
    vecs[13] = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 7'b0000000, 2'b00};
    vecs[14] = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 7'b1111111, 2'b01};
    vecs[15] = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 7'b1111100, 2'b00};

    idle();
    reset = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("reset_ctl", 32'(ctl()), 32'h00);
    next_cycle();
    reset = 1'b0;
    chk("reset_state", 32'(State), 32'h0);
    chk("reset_timeout", 32'(Mem_Timeout), 32'h0);
`ifdef HAZARD_PERF_CNT_EN
    chk("reset_stall_cnt", Stall_Count, 32'h0);
    chk("reset_flush_cnt", Flush_Count, 32'h0);
`endif

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i), 32'(ctl()), 32'(vecs[i].exp_ctl));
      chk($sformatf("vec%0d_state", i), 32'(State), 32'(vecs[i].exp_state));
      next_cycle();
    end
    idle();

    // memory access: 3 not-ready cycles then ready
`ifdef HAZARD_PERF_CNT_EN
    s0 = Stall_Count;
`endif
    for (int k = 0; k < 3; k++) begin
      MEM_Req = 1'b1; MEM_Ready = 1'b0;
      @(negedge clk);
      chk($sformatf("mem_frozen%0d", k), 32'(ctl()), 32'h00);
      chk($sformatf("mem_state%0d", k), 32'(State), (k == 0) ? 32'h0 : 32'h1);
      next_cycle();
    end
    MEM_Ready = 1'b1;
    @(negedge clk);
    chk("mem_ready_ctl", 32'(ctl()), 32'h7C);
    chk("mem_ready_state", 32'(State), 32'h1);
    next_cycle();
    idle();
    chk("mem_back_run", 32'(State), 32'h0);
`ifdef HAZARD_PERF_CNT_EN
    chk("mem_stall_cnt", Stall_Count - s0, 32'd3);
`endif

    // watchdog with MEM_TIMEOUT=4
    MEM_Req = 1'b1; MEM_Ready = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      next_cycle();
      if (e == 4) chk("to_edge4_state", 32'(State), 32'h1);
      if (e == 4) chk("to_edge4_flag", 32'(Mem_Timeout), 32'h0);
    end
    chk("to_halt_state", 32'(State), 32'h3);
    chk("to_halt_flag", 32'(Mem_Timeout), 32'h1);
    idle();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("halt%0d_state", c), 32'(State), 32'h3);
      chk($sformatf("halt%0d_flag", c), 32'(Mem_Timeout), 32'h1);
      chk($sformatf("halt%0d_ctl", c), 32'(ctl()), 32'h00);
      next_cycle();
    end

    // reset pulse out of HALT
    reset = 1'b1;
    @(negedge clk);
    chk("rst_halt_ctl", 32'(ctl()), 32'h00);
    next_cycle();
    reset = 1'b0;
    chk("rst_halt_state", 32'(State), 32'h0);
    chk("rst_halt_flag", 32'(Mem_Timeout), 32'h0);
`ifdef HAZARD_PERF_CNT_EN
    chk("rst_halt_stall_cnt", Stall_Count, 32'h0);
    chk("rst_halt_flush_cnt", Flush_Count, 32'h0);
`endif
    @(negedge clk);
    chk("rst_halt_resume", 32'(ctl()), 32'h7C);
    next_cycle();

    // branch with simultaneous load-use
`ifdef HAZARD_PERF_CNT_EN
    s0 = Stall_Count; f0 = Flush_Count;
`endif
    drive(vecs[7]);
    @(negedge clk);
    chk("br_lu_ctl", 32'(ctl()), 32'h7F);
    next_cycle();
    idle();
`ifdef HAZARD_PERF_CNT_EN
    chk("br_lu_flush_cnt", Flush_Count - f0, 32'd1);
    chk("br_lu_stall_cnt", Stall_Count - s0, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing controller for the 5-stage RV32I core. It generates the per-stage write-enable and flush controls around the forwarding datapath. It covers the three hazards forwarding cannot resolve: load-use dependencies, taken branches resolved in EX, and multi-cycle data-memory accesses. It sits beside the forwarding unit and drives the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. A watchdog halts the pipeline if memory never answers.

## Interface
Parameters:
- `MEM_TIMEOUT`, 255: maximum consecutive MEM_WAIT cycles before HALT; legal range 1..65535.
- `CNT_W`, 32: width of the performance counters (used only with `HAZARD_PERF_CNT_EN`).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `IF_ID_RS1`, `IF_ID_RS2`  in  5  source registers of the instruction in ID.
- `IF_ID_UsesRS1`, `IF_ID_UsesRS2`  in  1  source field is actually read.
- `ID_EX_RD`  in  5  destination of the instruction in EX.
- `ID_EX_MemRead`  in  1  instruction in EX is a load.
- `EX_BranchTaken`  in  1  branch or jump in EX redirects the PC.
- `MEM_Req`  in  1  MEM stage has an active data-memory access.
- `MEM_Ready`  in  1  data memory completes the access this cycle.
- `PC_Write`, `IF_ID_Write`, `ID_EX_Write`, `EX_MEM_Write`, `MEM_WB_Write`  out  1  stage register enables.
- `IF_ID_Flush`, `ID_EX_Flush`  out  1  load a bubble (NOP, all control bits 0).
- `State`  out  2  00 RUN, 01 MEM_WAIT, 11 HALT.
- `Mem_Timeout`  out  1  sticky error flag; high while in HALT.
- `Stall_Count`, `Flush_Count`  out  CNT_W  exist only with `HAZARD_PERF_CNT_EN`.

## Operation
- Outputs are Mealy: decoded from the registered state and the current inputs.
- `State` and `Mem_Timeout` are registered.
- `load_use` = `ID_EX_MemRead` & `ID_EX_RD`≠0 & ((`IF_ID_UsesRS1` & `RS1`==`RD`) | (`IF_ID_UsesRS2` & `RS2`==`RD`)).
- `mem_stall` = `MEM_Req` & !`MEM_Ready`.
- RUN, priority mem_stall > branch > load_use > normal:
  - mem_stall: all five write enables 0, both flushes 0. Go to MEM_WAIT and load the timeout counter with 1.
  - `EX_BranchTaken`: all write enables 1, `IF_ID_Flush`=1, `ID_EX_Flush`=1. A simultaneous load_use is ignored because the dependent instruction is killed. Stay in RUN.
  - load_use: `PC_Write`=0, `IF_ID_Write`=0, `ID_EX_Flush`=1, remaining enables 1. Stay in RUN. Exactly one bubble results, because `ID_EX_MemRead`=0 on the next cycle.
  - otherwise: all write enables 1, both flushes 0.
- MEM_WAIT:
  - While mem_stall is true: all write enables 0, flushes 0. The counter increments.
  - When the counter reaches `MEM_TIMEOUT` with mem_stall still true: go to HALT and set `Mem_Timeout`.
  - When mem_stall is false (`MEM_Ready`=1 or `MEM_Req` dropped): outputs are evaluated exactly as in RUN for that cycle, using the same priority rules. Go to RUN. The counter clears.
- HALT: all write enables 0, flushes 0. The block leaves HALT only on `reset`.
- Arithmetic: the timeout counter is 16 bits and saturates at `MEM_TIMEOUT`. Performance counters wrap modulo 2^CNT_W.

## Timing
- `reset` sampled high at an edge puts the block in these values after that edge:
  - `State`=RUN, `Mem_Timeout`=0, timeout counter 0, counters 0.
  - While `reset` is high, outputs are forced to: all write enables 0, flushes 0.
- `reset` asserted in MEM_WAIT or HALT returns the block to RUN at the next edge, with no residual stall.
- Load-use costs 1 cycle and branch flush costs 2 squashed instructions. There is no extra controller latency, since decisions are combinational in the detecting cycle.
- A memory access taking N cycles until `MEM_Ready` produces N−1 frozen cycles.
- `MEM_Req` with `MEM_Ready` already high in the same cycle produces no stall.
- HALT is entered at the edge ending the `MEM_TIMEOUT`-th consecutive stalled cycle in MEM_WAIT.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `Stall_Count` increments on every cycle with `PC_Write`=0 and `reset`=0.
  - `Flush_Count` increments on every cycle with `IF_ID_Flush`=1.
  - Both clear on `reset`.
- `HAZARD_PERF_CNT_EN` undefined: both ports and both counters are absent. All other behaviour is identical.

## Test plan
- Load-use, case 1. Stimulus: `ID_EX_MemRead`=1, `ID_EX_RD`=5, `IF_ID_RS2`=5, `UsesRS2`=1. Response: `PC_Write`=0, `IF_ID_Write`=0, `ID_EX_Flush`=1 for exactly one cycle, `State` stays 00.
- Load-use, case 2. Stimulus: same as case 1 but `ID_EX_RD`=0, or `UsesRS2`=0. Response: no stall.
- Branch plus load-use in the same cycle. Response: `IF_ID_Flush`=1, `ID_EX_Flush`=1, `PC_Write`=1. With `HAZARD_PERF_CNT_EN`, `Flush_Count` increments by 1 and `Stall_Count` is unchanged.
- Memory access. Stimulus: `MEM_Req`=1, `MEM_Ready` low for 3 cycles then high. Response: 3 frozen cycles, `State` 01 for 3 cycles, back to 00 after the ready cycle; `Stall_Count`=3.
- Timeout. Stimulus: `MEM_TIMEOUT`=4, `MEM_Ready` held low. Response: `State`=11 and `Mem_Timeout`=1 after 5 edges from the request, then held for 20 more cycles.
- Reset mid-HALT. Stimulus: `reset` pulsed for 1 cycle. Response: `State`=00, `Mem_Timeout`=0, counters 0, next cycle all write enables 1.
